// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants, FSM state and grant-source encodings for
//               the register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int RV_DATA_WIDTH = 32;
    localparam int RV_ADDR_WIDTH = 5;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_priority_arbiter.sv
// ============================================================================
// Module      : wb_priority_arbiter
// Description : Two-input writeback select, LSU-priority with ALU
//               starvation override after STARVE_LIMIT denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_priority_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_alu_valid,
    input  logic i_lsu_valid,
    output logic o_alu_ready,
    output logic o_lsu_ready
);

    localparam int                c_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0]   c_LIMIT = c_SW'(STARVE_LIMIT);

    logic [c_SW-1:0] r_starve;
    logic            w_force;
    logic            w_alu_win;
    logic            w_lsu_win;

    assign w_force   = (r_starve == c_LIMIT);
    assign w_alu_win = i_en & i_alu_valid & (~i_lsu_valid | w_force);
    assign w_lsu_win = i_en & i_lsu_valid & ~w_alu_win;

    assign o_alu_ready = w_alu_win;
    assign o_lsu_ready = w_lsu_win;

    // Only denials during arbitration count; the init phase is not a denial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!i_en || !i_alu_valid || w_alu_win) begin
            r_starve <= '0;
        end else if (r_starve != c_LIMIT) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Zero-initialises the register file after reset, then shares
//               its single write port between ALU and LSU writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH   = RV_DATA_WIDTH,
    parameter int ADDR_WIDTH   = RV_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  init_busy,
    output logic                  grant_src
);

    localparam logic [ADDR_WIDTH-1:0] c_INIT_FIRST = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_INIT_LAST  = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  w_init;
    logic                  w_init_drive;

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_reg;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_grant_src;

    assign w_init = (r_state == ST_INIT);

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_INIT && r_init_cnt == c_INIT_LAST) begin
            w_next_state = ST_ARB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= c_INIT_FIRST;
        end else begin
            r_state <= w_next_state;
            if (w_init && r_init_cnt != c_INIT_LAST) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    wb_priority_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk         (clk),
        .rst         (reset),
        .i_en        (~w_init),
        .i_alu_valid (alu_valid),
        .i_lsu_valid (lsu_valid),
        .o_alu_ready (alu_ready),
        .o_lsu_ready (lsu_ready)
    );

    // Init writes leave the registers tracking the counter so that the held
    // address after init is the last register written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant_src  <= SRC_ALU;
        end else if (w_init) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= r_init_cnt;
            r_write_data <= '0;
            r_grant_src  <= SRC_ALU;
        end else if (alu_ready) begin
            r_reg_write <= (alu_rd != '0);
            if (alu_rd != '0) begin
                r_write_reg  <= alu_rd;
                r_write_data <= alu_data;
                r_grant_src  <= SRC_ALU;
            end
        end else if (lsu_ready) begin
            r_reg_write <= (lsu_rd != '0);
            if (lsu_rd != '0) begin
                r_write_reg  <= lsu_rd;
                r_write_data <= lsu_data;
                r_grant_src  <= SRC_LSU;
            end
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Init writes are issued in the same cycle the counter holds the index;
    // reset masks them so the write port is idle while reset is asserted.
    assign w_init_drive = w_init & ~reset;

    assign reg_write  = w_init_drive ? 1'b1       : r_reg_write;
    assign write_reg  = w_init_drive ? r_init_cnt : r_write_reg;
    assign write_data = w_init_drive ? '0         : r_write_data;
    assign grant_src  = w_init_drive ? SRC_ALU    : r_grant_src;
    assign init_busy  = w_init;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter with a write
//               scoreboard and an independent arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        init_busy;
    logic        grant_src;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        src;
    } wr_t;

    wr_t      sb[$];
    int       n_chk;
    int       n_fail;
    int       m_starve;

    regfile_wb_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .init_busy  (init_busy),
        .grant_src  (grant_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One arbitration cycle: drive, check last cycle's write, check readies.
    task automatic arb_cycle(input string tag,
                             input logic av, input logic [4:0] ard, input logic [31:0] adata,
                             input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                             output logic a_exp, output logic a_dut);
        wr_t  e;
        logic ea, el;
        @(posedge clk);
        #1;
        alu_valid = av; alu_rd = ard; alu_data = adata;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldata;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (reg_write !== e.we) begin
                n_fail++;
                $display("FAIL %s reg_write: got %b expected %b", tag, reg_write, e.we);
            end
            if (e.we) begin
                n_chk++;
                if ({write_reg, write_data, grant_src} !== {e.rd, e.data, e.src}) begin
                    n_fail++;
                    $display("FAIL %s write: got rd=%0d data=%h src=%b expected rd=%0d data=%h src=%b",
                             tag, write_reg, write_data, grant_src, e.rd, e.data, e.src);
                end
            end
        end
        ea = av && (!lv || m_starve == 4);
        el = lv && !ea;
        n_chk++;
        if ({alu_ready, lsu_ready, init_busy} !== {ea, el, 1'b0}) begin
            n_fail++;
            $display("FAIL %s ready: got alu=%b lsu=%b busy=%b expected alu=%b lsu=%b busy=0",
                     tag, alu_ready, lsu_ready, init_busy, ea, el);
        end
        if (ea)      sb.push_back('{we: (ard != 5'd0), rd: ard, data: adata, src: 1'b0});
        else if (el) sb.push_back('{we: (lrd != 5'd0), rd: lrd, data: ldata, src: 1'b1});
        else         sb.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0, src: 1'b0});
        if (av && !ea) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
        else           m_starve = 0;
        a_exp = ea;
        a_dut = alu_ready;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; lsu_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({reg_write, write_reg, write_data, grant_src, init_busy, alu_ready, lsu_ready} !==
            {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b rd=%0d data=%h src=%b busy=%b ar=%b lr=%b expected 0 0 0 0 1 0 0",
                     reg_write, write_reg, write_data, grant_src, init_busy, alu_ready, lsu_ready);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    // Caller holds reset asserted; this releases it and checks the full sequence.
    task automatic run_init(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1111_2222;
        for (int k = 1; k <= 31; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            n_chk++;
            if ({reg_write, write_reg, write_data, alu_ready, lsu_ready, init_busy} !==
                {1'b1, 5'(k), 32'd0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL %s step%0d: got we=%b rd=%0d data=%h ar=%b lr=%b busy=%b expected we=1 rd=%0d data=0 ar=0 lr=0 busy=1",
                         tag, k, reg_write, write_reg, write_data, alu_ready, lsu_ready, init_busy, k);
            end
        end
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({init_busy, reg_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s end: got busy=%b we=%b expected busy=0 we=0", tag, init_busy, reg_write);
        end
        sb.delete();
        m_starve = 0;
    endtask

    task automatic test_single_alu();
        logic ae, ad;
        arb_cycle("single_alu", 1'b1, 5'd3, 32'h8765_4321, 1'b0, 5'd0, 32'd0, ae, ad);
        arb_cycle("single_alu_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ae, ad);
    endtask

    task automatic test_both_valid();
        logic ae, ad;
        arb_cycle("both_lsu_first", 1'b1, 5'd4, 32'hABCD_EF01, 1'b1, 5'd6, 32'hFEDC_BA09, ae, ad);
        arb_cycle("both_alu_second", 1'b1, 5'd4, 32'hABCD_EF01, 1'b0, 5'd0, 32'd0, ae, ad);
        arb_cycle("both_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ae, ad);
    endtask

    task automatic test_starvation();
        logic       ae, ad;
        logic [4:0] ard;
        int         n_alu;
        int         first_alu;
        ard = 5'd10;
        n_alu = 0;
        first_alu = -1;
        for (int i = 0; i < 10; i++) begin
            arb_cycle("starve", 1'b1, ard, 32'hA000_0000 + 32'(ard), 1'b1, 5'(16 + i),
                      32'hB000_0000 + 32'(i), ae, ad);
            if (ad === 1'b1) begin
                n_alu++;
                if (first_alu < 0) first_alu = i;
            end
            if (ae) ard = ard + 5'd1;
        end
        n_chk++;
        if (n_alu !== 2 || first_alu !== 4) begin
            n_fail++;
            $display("FAIL starve_ratio: got alu_wins=%0d first=%0d expected alu_wins=2 first=4", n_alu, first_alu);
        end
        arb_cycle("starve_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ae, ad);
    endtask

    task automatic test_rd_zero();
        logic ae, ad;
        arb_cycle("rd_zero", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555_5555, ae, ad);
        arb_cycle("rd_zero_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ae, ad);
    endtask

    task automatic test_back_to_back();
        logic ae, ad;
        for (int i = 0; i < 4; i++) begin
            arb_cycle("b2b_alu", 1'b1, 5'(20 + i), 32'hC0DE_0000 + 32'(i), 1'b0, 5'd0, 32'd0, ae, ad);
        end
        for (int i = 0; i < 3; i++) begin
            arb_cycle("b2b_lsu", 1'b0, 5'd0, 32'd0, 1'b1, 5'(28 + i), 32'hD00D_0000 + 32'(i), ae, ad);
        end
        arb_cycle("b2b_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ae, ad);
    endtask

    task automatic test_reset_mid_init();
        int   guard;
        logic hit;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 40) begin
            @(negedge clk);
            if (write_reg === 5'd10) hit = 1'b1;
            else @(posedge clk);
            guard++;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_init_reach: got write_reg=%0d expected 10 within 40 cycles", write_reg);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({reg_write, write_reg, init_busy} !== {1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_init_reset: got we=%b rd=%0d busy=%b expected we=0 rd=0 busy=1",
                     reg_write, write_reg, init_busy);
        end
        run_init("reinit");
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_starve = 0;
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        test_reset();
        run_init("init");
        test_single_alu();
        test_both_valid();
        test_starvation();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_init();
        test_single_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences and shares the single write port of `register_file` between two writeback requesters: the ALU and the load/store unit (LSU).
- After reset, an init sequence writes zero to every architectural register. It then arbitrates writeback requests with valid/ready handshakes.
- Sits between the execute/memory stages and `register_file`, and drives its write address, write data and write enable.

Parameters:
- DATA_WIDTH, 32: width of register data.
- ADDR_WIDTH, 5: register index width; the register file has 2^ADDR_WIDTH entries.
- STARVE_LIMIT, 4: consecutive denied ALU-request cycles after which the ALU is forced to win the next grant.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- lsu_valid  input  1  LSU writeback request.
- lsu_rd  input  ADDR_WIDTH  LSU destination register.
- lsu_data  input  DATA_WIDTH  load data.
- lsu_ready  output  1  LSU request accepted this cycle.
- reg_write  output  1  write enable to `register_file`.
- write_reg  output  ADDR_WIDTH  write address to `register_file`.
- write_data  output  DATA_WIDTH  write data to `register_file`.
- init_busy  output  1  high while the zero-init sequence runs.
- grant_src  output  1  source of the current write (0 = ALU, 1 = LSU); valid when reg_write = 1.

Behaviour:
- Reset values (async, immediate): state = INIT, init counter = 1, starve counter = 0, reg_write = 0, write_reg = 0, write_data = 0, grant_src = 0, init_busy = 1. alu_ready and lsu_ready are 0 throughout INIT.
- States: INIT, ARB.
- INIT:
  - Each cycle: reg_write = 1, write_reg = init counter, write_data = 0.
  - The counter increments 1 .. 2^ADDR_WIDTH-1.
  - Register 0 is never written. That is 31 write cycles at default parameters.
  - On the cycle the counter equals 2^ADDR_WIDTH-1, the write is issued, the next state is ARB, and init_busy drops in the first ARB cycle.
- ARB, readiness: alu_ready and lsu_ready are combinational from the current valids and the starve counter. At most one is high per cycle.
- ARB, grant rule:
  - Only one valid: that source wins.
  - Both valid: LSU wins, unless starve counter == STARVE_LIMIT, in which case ALU wins.
- Starve counter:
  - Increments each cycle alu_valid = 1 and alu_ready = 0; saturates at STARVE_LIMIT.
  - Clears on any ALU acceptance, or on any cycle alu_valid = 0.
- Latency: a request accepted in cycle N (valid & ready) appears on write_reg/write_data/grant_src with reg_write = 1 in cycle N+1. The outputs are registered.
- No acceptance in cycle N: reg_write = 0 in N+1; write_reg, write_data and grant_src hold their previous values.
- rd == 0: the handshake completes (ready = 1) but reg_write stays 0 in N+1, so x0 stays zero.
- Requester rules:
  - A requester holds valid, rd and data stable until ready.
  - The arbiter never drops an accepted request; there is exactly one write per handshake.
  - The denied requester's request remains pending; the arbiter stores nothing for it.
- Back-to-back: a new acceptance is allowed every cycle (throughput 1 write/cycle).
- Reset asserted mid-INIT or mid-ARB: immediate return to reset values. A pending write in flight is discarded and INIT restarts from register 1.
- Counters wrap never: the init counter stops at its terminal value; the starve counter saturates.

Decomposition:
- Shared package `rv_pkg`: constants DATA_WIDTH/ADDR_WIDTH defaults, state encoding (ST_INIT, ST_ARB), and the grant source encoding (SRC_ALU = 0, SRC_LSU = 1).
- One natural sub-module, `wb_priority_arbiter`: 2-input priority select with starvation override, containing the starve counter. The top module holds the FSM, the init counter and the output registers.

Test Plan:
- Reset, then run 31 cycles → reg_write = 1 with write_reg stepping 1..31, write_data = 0, readies 0. Cycle 32: init_busy = 0 and reg_write = 0.
- After init, alu_valid = 1, alu_rd = 3, alu_data = 32'h87654321 for one cycle → alu_ready = 1 that cycle. Next cycle: reg_write = 1, write_reg = 3, write_data = 32'h87654321, grant_src = 0.
- ALU (rd 4, 32'hABCDEF01) and LSU (rd 6, 32'hFEDCBA09) both valid → LSU accepted first (write to 6 next cycle). ALU accepted the following cycle (write to 4 the cycle after).
- ALU valid plus LSU valid continuously with changing rd → LSU wins 4 consecutive cycles, ALU wins the 5th, and the starve counter resets. The pattern repeats 4:1.
- lsu_valid with lsu_rd = 0, data 32'h55555555 → lsu_ready = 1, and reg_write stays 0 next cycle.
- Assert reset at init counter = 10 → reg_write = 0 immediately. After release, INIT restarts at write_reg = 1, and a full 31-cycle sequence follows.
